// File: rtl/generic_sram_port.sv
// Single-port SRAM behind a req/ack handshake: byte write mask, base/size range check
// and an optional output register that adds one cycle to reads.
//
// state | meaning
// IDLE  | waiting for req; the array access happens on the sampling edge
// PIPE  | OUTREG read: array word held in pipe_data_q, rd_data loads next edge
// ACK   | ack (and err for out-of-range) high for exactly this cycle
module generic_sram_port #(
    parameter int                AWIDTH = 32,
    parameter int                DWIDTH = 32,
    parameter int                KB     = 4,
    parameter logic [AWIDTH-1:0] BASE   = '0,
    parameter int                OUTREG = 0
) (
    input  logic                  clk,
    input  logic                  rstz,
    input  logic                  req,
    input  logic [AWIDTH-1:0]     addr,
    input  logic                  wr_en,
    input  logic [DWIDTH-1:0]     wr_data,
    input  logic [DWIDTH/8-1:0]   mask,
    output logic [DWIDTH-1:0]     rd_data,
    output logic                  ack,
    output logic                  err
);

    localparam int NBYTES = DWIDTH / 8;
    localparam int LSB    = $clog2(NBYTES);
    localparam int NWORDS = KB * 8192 / DWIDTH;
    localparam int IDXW   = $clog2(NWORDS);
    localparam logic [AWIDTH:0] BASE_X = {1'b0, BASE};
    localparam logic [AWIDTH:0] SIZE_X = (AWIDTH + 1)'(KB * 1024);

    typedef enum logic [1:0] {IDLE, PIPE, ACK} state_t;

    state_t              state_q, state_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [DWIDTH-1:0]   rd_data_q, rd_data_d;
    logic [DWIDTH-1:0]   pipe_data_q, pipe_data_d;
    logic                pipe_err_q, pipe_err_d;

    logic [DWIDTH-1:0]   mem [NWORDS];
    logic [IDXW-1:0]     idx;
    logic [AWIDTH:0]     offset;
    logic                in_range;
    logic                mem_we;
    logic [DWIDTH-1:0]   mem_rdata;

    // One extra bit makes addr < BASE wrap above any legal size, so a single compare suffices.
    assign offset    = {1'b0, addr} - BASE_X;
    assign in_range  = (offset < SIZE_X);
    assign idx       = addr[LSB +: IDXW];
    assign mem_rdata = mem[idx];
    assign mem_we    = rstz && (state_q == IDLE) && req && wr_en && in_range;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (mask[b]) begin
                    mem[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        rd_data_d   = rd_data_q;
        pipe_data_d = pipe_data_q;
        pipe_err_d  = pipe_err_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (wr_en || (OUTREG == 0)) begin
                        ack_d   = 1'b1;
                        err_d   = !in_range;
                        state_d = ACK;
                        if (!wr_en && in_range) begin
                            rd_data_d = mem_rdata;
                        end
                    end else begin
                        pipe_data_d = mem_rdata;
                        pipe_err_d  = !in_range;
                        state_d     = PIPE;
                    end
                end
            end
            PIPE: begin
                ack_d   = 1'b1;
                err_d   = pipe_err_q;
                state_d = ACK;
                if (!pipe_err_q) begin
                    rd_data_d = pipe_data_q;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstz) begin
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
            pipe_data_q <= '0;
            pipe_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rd_data_q   <= rd_data_d;
            pipe_data_q <= pipe_data_d;
            pipe_err_q  <= pipe_err_d;
        end
    end

    assign rd_data = rd_data_q;
    assign ack     = ack_q;
    assign err     = err_q;

endmodule

// File: tb/tb_generic_sram_port.sv
// Bench for generic_sram_port: four configurations driven from one stimulus process,
// expected responses queued per unit and checked by an independent monitor.
module tb_generic_sram_port;

    localparam int NU = 4;

    typedef struct {
        int          cyc;
        logic        err;
        logic [63:0] rd;
    } exp_t;

    logic clk = 1'b0;
    logic rstz;
    int   cyc = 0;

    logic        req   [NU];
    logic [31:0] addr  [NU];
    logic        wr_en [NU];
    logic [63:0] wdata [NU];
    logic [7:0]  mask  [NU];

    logic [31:0] rd0, rd1;
    logic [63:0] rd2, rd3;
    logic        ack0, ack1, ack2, ack3;
    logic        err0, err1, err2, err3;
    logic        ack_s [NU];
    logic        err_s [NU];
    logic [63:0] rd_s  [NU];

    exp_t        sb [NU][$];
    exp_t        mon_e;
    logic [63:0] mdl_mem [int];
    logic [63:0] mdl_rd  [NU];
    logic [63:0] mon_rd  [NU];
    int          prev_ack [NU];
    int          n_chk = 0;
    int          n_pass = 0;

    assign ack_s[0] = ack0;
    assign ack_s[1] = ack1;
    assign ack_s[2] = ack2;
    assign ack_s[3] = ack3;
    assign err_s[0] = err0;
    assign err_s[1] = err1;
    assign err_s[2] = err2;
    assign err_s[3] = err3;
    assign rd_s[0]  = {32'h0, rd0};
    assign rd_s[1]  = {32'h0, rd1};
    assign rd_s[2]  = rd2;
    assign rd_s[3]  = rd3;

    generic_sram_port #(.AWIDTH(32), .DWIDTH(32), .KB(1), .BASE(32'h0), .OUTREG(0)) u_d0 (
        .clk(clk), .rstz(rstz), .req(req[0]), .addr(addr[0]), .wr_en(wr_en[0]),
        .wr_data(wdata[0][31:0]), .mask(mask[0][3:0]), .rd_data(rd0), .ack(ack0), .err(err0));
    generic_sram_port #(.AWIDTH(32), .DWIDTH(32), .KB(1), .BASE(32'h0), .OUTREG(1)) u_d1 (
        .clk(clk), .rstz(rstz), .req(req[1]), .addr(addr[1]), .wr_en(wr_en[1]),
        .wr_data(wdata[1][31:0]), .mask(mask[1][3:0]), .rd_data(rd1), .ack(ack1), .err(err1));
    generic_sram_port #(.AWIDTH(32), .DWIDTH(64), .KB(1), .BASE(32'h0), .OUTREG(0)) u_d2 (
        .clk(clk), .rstz(rstz), .req(req[2]), .addr(addr[2]), .wr_en(wr_en[2]),
        .wr_data(wdata[2]), .mask(mask[2]), .rd_data(rd2), .ack(ack2), .err(err2));
    generic_sram_port #(.AWIDTH(32), .DWIDTH(64), .KB(2), .BASE(32'h1000), .OUTREG(1)) u_d3 (
        .clk(clk), .rstz(rstz), .req(req[3]), .addr(addr[3]), .wr_en(wr_en[3]),
        .wr_data(wdata[3]), .mask(mask[3]), .rd_data(rd3), .ack(ack3), .err(err3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dw_of(int u);
        return (u >= 2) ? 64 : 32;
    endfunction
    function automatic int kb_of(int u);
        return (u == 3) ? 2 : 1;
    endfunction
    function automatic longint base_of(int u);
        return (u == 3) ? 64'h1000 : 64'h0;
    endfunction
    function automatic bit oreg_of(int u);
        return (u == 1) || (u == 3);
    endfunction
    function automatic bit in_rng(int u, logic [31:0] a);
        longint la = longint'(a);
        return (la >= base_of(u)) && (la < base_of(u) + longint'(kb_of(u)) * 1024);
    endfunction
    function automatic int key_of(int u, logic [31:0] a);
        return u * 4096 + int'((longint'(a) - base_of(u)) / longint'(dw_of(u) / 8));
    endfunction

    task automatic check(string name, int u, logic [63:0] act, logic [63:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s unit=%0d cyc=%0d actual=%h required=%h", name, u, cyc, act, want);
    endtask

    // Presents one access at the current falling edge; the port samples it on the first
    // edge at least two edges after the previous ack, reads with OUTREG take one extra cycle.
    task automatic access(int u, bit w, logic [31:0] a, logic [63:0] d, logic [7:0] m, int gap);
        exp_t        e;
        int          n;
        int          k;
        logic [63:0] word;
        for (int i = 0; i < gap; i++) begin
            req[u] = 1'b0;
            @(negedge clk);
        end
        req[u] = 1'b1; wr_en[u] = w; addr[u] = a; wdata[u] = d; mask[u] = m;
        n = cyc + 1;
        if (n < prev_ack[u] + 2) n = prev_ack[u] + 2;
        e.err = !in_rng(u, a);
        if (!e.err) begin
            k = key_of(u, a);
            if (w) begin
                word = mdl_mem.exists(k) ? mdl_mem[k] : 64'h0;
                for (int b = 0; b < dw_of(u) / 8; b++)
                    if (m[b]) word[b*8 +: 8] = d[b*8 +: 8];
                mdl_mem[k] = word;
            end else begin
                mdl_rd[u] = mdl_mem[k];
            end
        end
        e.rd  = mdl_rd[u];
        e.cyc = n + ((!w && oreg_of(u)) ? 1 : 0);
        sb[u].push_back(e);
        prev_ack[u] = e.cyc;
        while (cyc < n) @(negedge clk);
        // Once sampled, the inputs must no longer matter.
        addr[u] = $urandom; wdata[u] = {$urandom, $urandom};
        mask[u] = 8'($urandom); wr_en[u] = 1'($urandom);
        while (cyc < e.cyc) @(negedge clk);
    endtask

    function automatic logic [31:0] pick_oor(int u);
        longint top = base_of(u) + longint'(kb_of(u)) * 1024;
        case ($urandom % 3)
            0:       return 32'(top + longint'(($urandom % 16) * (dw_of(u) / 8)));
            1:       return 32'h8000_0000 | $urandom;
            default: return (base_of(u) == 0) ? 32'hFFFF_FFFF - ($urandom % 64)
                                              : 32'(base_of(u) - longint'(8 * (1 + $urandom % 4)));
        endcase
    endfunction

    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int u = 0; u < NU; u++) begin
                if (!rstz) begin
                    check("ack_in_reset", u, ack_s[u], 1'b0);
                end else if (ack_s[u] === 1'b1) begin
                    if (sb[u].size() == 0) begin
                        check("unexpected_ack", u, ack_s[u], 1'b0);
                    end else begin
                        mon_e = sb[u].pop_front();
                        check("ack_cycle", u, cyc, mon_e.cyc);
                        check("err", u, err_s[u], mon_e.err);
                        check("rd_data", u, rd_s[u], mon_e.rd);
                        mon_rd[u] = mon_e.rd;
                    end
                end else begin
                    check("err_without_ack", u, err_s[u], 1'b0);
                    check("rd_hold", u, rd_s[u], mon_rd[u]);
                    if (sb[u].size() > 0 && sb[u][0].cyc <= cyc) begin
                        check("missing_ack", u, ack_s[u], 1'b1);
                        void'(sb[u].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1);
    end

    initial begin
        int          n;
        int          bytes;
        logic [31:0] a;
        for (int u = 0; u < NU; u++) begin
            req[u] = 1'b0; addr[u] = '0; wr_en[u] = 1'b0; wdata[u] = '0; mask[u] = '0;
            mdl_rd[u] = '0; mon_rd[u] = '0; prev_ack[u] = -10;
        end
        // A request held through reset must only be taken after release.
        rstz = 1'b0;
        req[0] = 1'b1; wr_en[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 64'hDEADBEEF; mask[0] = 8'hF;
        repeat (3) @(negedge clk);
        rstz = 1'b1;
        check("rd_after_reset", 0, rd_s[0], 64'h0);

        access(0, 1'b1, 32'h10,  64'hDEADBEEF, 8'hF, 0);
        access(0, 1'b0, 32'h10,  64'h0,        8'h0, 0);
        access(0, 1'b1, 32'h10,  64'h11223344, 8'h5, 1);
        access(0, 1'b0, 32'h10,  64'h0,        8'h0, 0);
        access(0, 1'b1, 32'h0,   64'hCAFEF00D, 8'hF, 0);
        access(0, 1'b0, 32'h400, 64'h0,        8'h0, 0);
        access(0, 1'b1, 32'h400, 64'h55555555, 8'hF, 0);
        access(0, 1'b1, 32'hFFFF_FC00, 64'h66666666, 8'hF, 2);
        access(0, 1'b0, 32'h0,   64'h0,        8'h0, 0);
        access(0, 1'b1, 32'h10,  64'hFFFFFFFF, 8'h0, 0);
        access(0, 1'b0, 32'h13,  64'h0,        8'h0, 0);
        req[0] = 1'b0;

        access(1, 1'b1, 32'h10,  64'hDEADBEEF, 8'hF, 1);
        access(1, 1'b0, 32'h10,  64'h0,        8'h0, 0);
        access(1, 1'b0, 32'h10,  64'h0,        8'h0, 0);
        access(1, 1'b0, 32'h400, 64'h0,        8'h0, 0);
        req[1] = 1'b0;
        repeat (2) @(negedge clk);
        // Reset lands while the read sits in PIPE: that access never acks.
        req[1] = 1'b1; wr_en[1] = 1'b0; addr[1] = 32'h10;
        n = cyc + 1;
        while (cyc < n) @(negedge clk);
        rstz = 1'b0; req[1] = 1'b0;
        for (int u = 0; u < NU; u++) begin
            mdl_rd[u] = '0; mon_rd[u] = '0; prev_ack[u] = -10;
        end
        repeat (2) @(negedge clk);
        rstz = 1'b1;
        check("rd_after_reset", 1, rd_s[1], 64'h0);
        access(1, 1'b0, 32'h10, 64'h0, 8'h0, 1);
        req[1] = 1'b0;

        access(2, 1'b1, 32'h8, 64'h0,                 8'hFF, 1);
        access(2, 1'b1, 32'h8, 64'h0123456789ABCDEF, 8'hF0, 0);
        access(2, 1'b0, 32'h8, 64'h0,                 8'h00, 0);
        req[2] = 1'b0;

        access(3, 1'b1, 32'h1000, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 1);
        access(3, 1'b0, 32'h1007, 64'h0, 8'h0, 0);
        access(3, 1'b0, 32'h0FF8, 64'h0, 8'h0, 0);
        access(3, 1'b1, 32'h1800, 64'h1, 8'hFF, 0);
        access(3, 1'b0, 32'h1000, 64'h0, 8'h0, 0);
        req[3] = 1'b0;

        for (int u = 0; u < NU; u++) begin
            bytes = dw_of(u) / 8;
            for (int w = 0; w < 16; w++)
                access(u, 1'b1, 32'(base_of(u) + longint'(w * bytes)), {$urandom, $urandom}, 8'hFF, 0);
            for (int i = 0; i < 150; i++) begin
                if ($urandom % 10 < 3) a = pick_oor(u);
                else a = 32'(base_of(u) + longint'(($urandom % 16) * bytes + $urandom % bytes));
                access(u, 1'($urandom), a, {$urandom, $urandom}, 8'($urandom), int'($urandom % 3));
            end
            req[u] = 1'b0;
            repeat (3) @(negedge clk);
        end

        repeat (6) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/generic_sram_port.md
GENERIC_SRAM_PORT -- requirements
Module: generic_sram_port

Interface
REQ-001 Parameter AWIDTH, default 32, byte address width.
REQ-002 Parameter DWIDTH, default 32, data width; legal values 32 and 64.
REQ-003 Parameter KB, default 4, capacity in KB, power of two; NWORDS = KB*8192/DWIDTH.
REQ-004 Parameter BASE, default 0, base byte address; SHALL be aligned to KB*1024.
REQ-005 Parameter OUTREG, default 0, read output register; 0 = one-cycle reads, 1 = two-cycle reads.
REQ-006 Port clk, input, 1, sole clock; all logic on rising edge.
REQ-007 Port rstz, input, 1, reset: synchronous, active-low.
REQ-008 Port req, input, 1, access request; held by master until ack.
REQ-009 Port addr, input, AWIDTH, byte address; low log2(DWIDTH/8) bits ignored.
REQ-010 Port wr_en, input, 1, 1 = write, 0 = read.
REQ-011 Port wr_data, input, DWIDTH, write data.
REQ-012 Port mask, input, DWIDTH/8, per-byte write enable; ignored on reads.
REQ-013 Port rd_data, output, DWIDTH, read data.
REQ-014 Port ack, output, 1, single-cycle completion pulse.
REQ-015 Port err, output, 1, out-of-range flag; valid only while ack=1.

Function
REQ-016 Storage SHALL be NWORDS x DWIDTH; word index = addr[LSB +: log2(NWORDS)], LSB = log2(DWIDTH/8).
REQ-017 In range SHALL mean BASE <= addr < BASE + KB*1024, over full AWIDTH.
REQ-018 FSM states SHALL be IDLE, PIPE and ACK.
REQ-019 IDLE with req=1 at edge N SHALL latch request and perform the memory access at that edge; next state is ACK (OUTREG=0 or write) or PIPE (OUTREG=1 read).
REQ-020 PIPE SHALL register the array output into rd_data and go to ACK.
REQ-021 ACK SHALL drive ack=1 for exactly one cycle and return to IDLE; req is not sampled in PIPE or ACK.
REQ-022 Latency from req sampled at edge N: write ack and OUTREG=0 read ack SHALL be in cycle N+1; OUTREG=1 read ack in cycle N+2.
REQ-023 With req held high, throughput SHALL be one access per 2 cycles (3 for OUTREG=1 reads).
REQ-024 Write SHALL update only the bytes whose mask bit is 1; mask=0 SHALL complete with ack and leave memory unchanged.
REQ-025 rd_data SHALL change only on in-range read completion and hold its value otherwise, including across writes.
REQ-026 Out-of-range access SHALL leave memory and rd_data unchanged, with ack=1 and err=1 in the normal ack cycle.
REQ-027 err SHALL be 0 whenever ack=0.
REQ-028 Read and write to the same word in successive accesses SHALL return the written data.
REQ-029 Address and data inputs SHALL be captured in IDLE; later input changes do not affect the access in flight.

Reset
REQ-030 rstz=0 at an edge SHALL force IDLE, ack=0, err=0, rd_data=0.
REQ-031 Reset SHALL NOT clear array contents; a write committed before reset persists.
REQ-032 Reset in PIPE or ACK SHALL drop the pending ack; no ack is issued for that access.
REQ-033 req SHALL be ignored while rstz=0; sampling resumes on the first edge with rstz=1.

Verification
REQ-034 DWIDTH=32, KB=1, BASE=0: write 0xDEADBEEF, mask 0xF, addr 0x10, then read 0x10 -> acks in N+1, rd_data=0xDEADBEEF, err=0.
REQ-035 Write 0x11223344, mask 0x5, to a word holding 0xDEADBEEF, then read -> 0xDE22BE44.
REQ-036 Read addr 0x400 (KB=1) -> ack=err=1 in N+1, rd_data unchanged; write 0x400 -> memory unchanged.
REQ-037 OUTREG=1: read addr 0x10 -> no ack in N+1, ack in N+2 with 0xDEADBEEF; req held high -> next ack in N+5.
REQ-038 rstz=0 in PIPE during a read -> no ack, rd_data=0; after release, read 0x10 -> 0xDEADBEEF.
REQ-039 DWIDTH=64: write 0x0123456789ABCDEF, mask 0xF0, to a zeroed word at addr 0x8, then read -> 0x0123456700000000.
